// File: rtl/fish_pos_ctrl.sv
// Purpose: per-fish position integrator; handles spawn, swim, edge escape and hook capture/reel-in.
// Latency: all outputs registered; 1 cycle from inputs (spawn, steps, hook coords) to outputs.
// Backpressure: none; hm/vm consumed every cycle, spawn outside IDLE is dropped (no queuing).
module fish_pos_ctrl #(
   parameter int H_MAX     = 640,
   parameter int V_MAX     = 480,
   parameter int FISH_W    = 32,
   parameter int FISH_H    = 16,
   parameter int SURFACE_Y = 80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spawn,
   input  logic [9:0] spawn_x,
   input  logic [8:0] spawn_y,
   input  logic [1:0] way,
   input  logic [2:0] hm,
   input  logic [2:0] vm,
   input  logic       hook_en,
   input  logic [9:0] hook_x,
   input  logic [8:0] hook_y,
   output logic [9:0] fish_x,
   output logic [8:0] fish_y,
   output logic       active,
   output logic       caught,
   output logic       escaped,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SWIM   = 2'd1,
      S_CAUGHT = 2'd2
   } state_t;

   // Parameter sanity: the sprite must fit on screen and the surface must lie inside it.
   if (FISH_W > H_MAX || FISH_H > V_MAX || SURFACE_Y >= V_MAX) begin : g_bad_params
      $error("fish_pos_ctrl: inconsistent screen/sprite parameters");
   end

   // 11-bit constants so every compare and sum below has headroom and never wraps.
   localparam logic [10:0] X_LIM  = 11'(H_MAX - FISH_W);
   localparam logic [10:0] SURF   = 11'(SURFACE_Y);
   localparam logic [10:0] W_M1   = 11'(FISH_W - 1);
   localparam logic [10:0] H_M1   = 11'(FISH_H - 1);
   localparam logic [10:0] HALF_W = 11'(FISH_W / 2);

   state_t      state_q, state_d;
   logic [1:0]  dir_q, dir_d;
   logic [9:0]  fish_x_q, fish_x_d;
   logic [8:0]  fish_y_q, fish_y_d;
   logic        active_q, active_d;
   logic        caught_q, caught_d;
   logic        escaped_q, escaped_d;

   logic [10:0] fx_w, fy_w, hx_w, hy_w, hm_w, vm_w, hx_off;
   logic        hit;

   assign fx_w   = {1'b0, fish_x_q};
   assign fy_w   = {2'b0, fish_y_q};
   assign hx_w   = {1'b0, hook_x};
   assign hy_w   = {2'b0, hook_y};
   assign hm_w   = {8'b0, hm};
   assign vm_w   = {8'b0, vm};
   assign hx_off = hx_w - HALF_W;

   // Hook tip inside the fish bounding box.
   assign hit = hook_en &&
                (hx_w >= fx_w) && (hx_w <= fx_w + W_M1) &&
                (hy_w >= fy_w) && (hy_w <= fy_w + H_M1);

   // Next-state, next-position and pulse generation.
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      fish_x_d  = fish_x_q;
      fish_y_d  = fish_y_q;
      active_d  = active_q;
      caught_d  = 1'b0;
      escaped_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            active_d = 1'b0;
            if (spawn) begin
               fish_x_d = spawn_x;
               fish_y_d = spawn_y;
               dir_d    = way;
               active_d = 1'b1;
               state_d  = S_SWIM;
            end
         end
         S_SWIM: begin
            if (hit) begin
               // Capture wins over movement and escape this cycle.
               state_d = S_CAUGHT;
            end else begin
               case (dir_q)
                  2'd0: begin
                     if (hm_w > fx_w) begin
                        escaped_d = 1'b1;
                        active_d  = 1'b0;
                        state_d   = S_IDLE;
                     end else begin
                        fish_x_d = fish_x_q - {7'b0, hm};
                     end
                  end
                  2'd1: begin
                     if ((hm != 3'd0) && (fx_w + hm_w > X_LIM)) begin
                        escaped_d = 1'b1;
                        active_d  = 1'b0;
                        state_d   = S_IDLE;
                     end else begin
                        fish_x_d = fish_x_q + {7'b0, hm};
                     end
                  end
                  2'd2: begin
                     if ((vm != 3'd0) && (fy_w < SURF + vm_w)) begin
                        escaped_d = 1'b1;
                        active_d  = 1'b0;
                        state_d   = S_IDLE;
                     end else begin
                        fish_y_d = fish_y_q - {6'b0, vm};
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_CAUGHT: begin
            if (!hook_en) begin
               state_d = S_SWIM;
            end else if (hy_w <= SURF) begin
               caught_d = 1'b1;
               active_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               // Fish hangs centred under the hook, kept fully on screen.
               fish_y_d = hook_y;
               if (hx_w < HALF_W)       fish_x_d = 10'd0;
               else if (hx_off > X_LIM) fish_x_d = X_LIM[9:0];
               else                     fish_x_d = hx_off[9:0];
            end
         end
         default: begin
            state_d  = S_IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dir_q     <= 2'd0;
         fish_x_q  <= 10'd0;
         fish_y_q  <= 9'd0;
         active_q  <= 1'b0;
         caught_q  <= 1'b0;
         escaped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         fish_x_q  <= fish_x_d;
         fish_y_q  <= fish_y_d;
         active_q  <= active_d;
         caught_q  <= caught_d;
         escaped_q <= escaped_d;
      end
   end

   assign fish_x  = fish_x_q;
   assign fish_y  = fish_y_q;
   assign active  = active_q;
   assign caught  = caught_q;
   assign escaped = escaped_q;
   assign state   = state_q;

endmodule

// File: tb/tb_fish_pos_ctrl.sv
// Purpose: self-checking bench for fish_pos_ctrl; directed scenarios plus randomized traffic.
// Latency: model advances on each rising edge; outputs compared on every falling edge.
// Backpressure: none; stimulus is applied freely each cycle.
module tb_fish_pos_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spawn = 1'b0;
   logic [9:0] spawn_x = '0;
   logic [8:0] spawn_y = '0;
   logic [1:0] way = '0;
   logic [2:0] hm = '0;
   logic [2:0] vm = '0;
   logic       hook_en = 1'b0;
   logic [9:0] hook_x = '0;
   logic [8:0] hook_y = '0;
   logic [9:0] fish_x;
   logic [8:0] fish_y;
   logic       active, caught, escaped;
   logic [1:0] state;

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model state (plain integers).
   int m_st = 0, m_x = 0, m_y = 0, m_dir = 0, m_act = 0, m_cau = 0, m_esc = 0;

   fish_pos_ctrl dut (
      .clk(clk), .rst(rst), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .way(way), .hm(hm), .vm(vm), .hook_en(hook_en), .hook_x(hook_x), .hook_y(hook_y),
      .fish_x(fish_x), .fish_y(fish_y), .active(active), .caught(caught),
      .escaped(escaped), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: screen is 640x480, fish 32x16, surface at row 80.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0; m_x = 0; m_y = 0; m_dir = 0; m_act = 0; m_cau = 0; m_esc = 0;
      end else begin
         int hx, hy, s, c;
         hx = hook_x; hy = hook_y; s = hm; c = vm;
         m_cau = 0; m_esc = 0;
         if (m_st == 0) begin
            if (spawn) begin
               m_x = spawn_x; m_y = spawn_y; m_dir = way; m_act = 1; m_st = 1;
            end
         end else if (m_st == 1) begin
            if (hook_en && hx >= m_x && hx < m_x + 32 && hy >= m_y && hy < m_y + 16) begin
               m_st = 2;
            end else begin
               int nx, ny;
               nx = m_x; ny = m_y;
               if (m_dir == 0) nx = m_x - s;
               if (m_dir == 1) nx = m_x + s;
               if (m_dir == 2) ny = m_y - c;
               if (nx < 0 || nx > 608 || ny < 80 && c != 0 && m_dir == 2) begin
                  m_esc = 1; m_act = 0; m_st = 0;
               end else begin
                  m_x = nx; m_y = ny;
               end
            end
         end else begin
            if (!hook_en) m_st = 1;
            else if (hy <= 80) begin
               m_cau = 1; m_act = 0; m_st = 0;
            end else begin
               m_y = hy;
               m_x = (hx - 16 < 0) ? 0 : (hx - 16 > 608) ? 608 : hx - 16;
            end
         end
      end
   end

   // Compare every cycle while out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         check("state",   int'(state),   m_st);
         check("fish_x",  int'(fish_x),  m_x);
         check("fish_y",  int'(fish_y),  m_y);
         check("active",  int'(active),  m_act);
         check("caught",  int'(caught),  m_cau);
         check("escaped", int'(escaped), m_esc);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_spawn(input int x, input int y, input int w);
      spawn = 1'b1; spawn_x = 10'(x); spawn_y = 9'(y); way = 2'(w);
      tick();
      spawn = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      check("rst_state", int'(state), 0);
      check("rst_x", int'(fish_x), 0);
      check("rst_y", int'(fish_y), 0);
      check("rst_active", int'(active), 0);
      rst = 1'b0;

      // Spawn.
      do_spawn(300, 200, 1);
      check("spawn_state", int'(state), 1);
      check("spawn_active", int'(active), 1);
      check("spawn_x", int'(fish_x), 300);
      check("spawn_y", int'(fish_y), 200);

      // Spawn while swimming is ignored.
      do_spawn(10, 100, 0);
      check("ign_spawn_x", int'(fish_x), 300);
      check("ign_spawn_y", int'(fish_y), 200);

      // Right escape.
      do_reset();
      do_spawn(606, 200, 1);
      hm = 3'd1;
      tick(); check("right_x1", int'(fish_x), 607);
      tick(); check("right_x2", int'(fish_x), 608);
      tick();
      check("right_esc", int'(escaped), 1);
      check("right_act", int'(active), 0);
      check("right_state", int'(state), 0);
      check("right_hold", int'(fish_x), 608);
      hm = 3'd0;
      tick(); check("right_esc_pulse", int'(escaped), 0);

      // Left underflow, then zero step.
      do_reset();
      do_spawn(2, 200, 0);
      hm = 3'd3;
      tick();
      check("left_esc", int'(escaped), 1);
      check("left_hold", int'(fish_x), 2);
      hm = 3'd0;
      do_reset();
      do_spawn(2, 200, 0);
      tick();
      check("left_zero_x", int'(fish_x), 2);
      check("left_zero_esc", int'(escaped), 0);
      check("left_zero_state", int'(state), 1);

      // Capture has priority over movement.
      do_reset();
      do_spawn(100, 200, 1);
      hook_en = 1'b1; hook_x = 10'd110; hook_y = 9'd205; hm = 3'd1;
      tick();
      check("cap_state", int'(state), 2);
      check("cap_x", int'(fish_x), 100);
      tick();
      check("cap_follow_x", int'(fish_x), 94);
      check("cap_follow_y", int'(fish_y), 205);

      // Reel to surface.
      hook_y = 9'd150; tick();
      check("reel_y", int'(fish_y), 150);
      hook_y = 9'd80; tick();
      check("reel_caught", int'(caught), 1);
      check("reel_act", int'(active), 0);
      check("reel_state", int'(state), 0);
      tick();
      check("reel_pulse", int'(caught), 0);
      hm = 3'd0;

      // Release variant.
      do_reset();
      do_spawn(100, 200, 1);
      hook_en = 1'b1; hook_x = 10'd110; hook_y = 9'd205;
      tick();
      hook_y = 9'd120; tick();
      hook_en = 1'b0; tick();
      check("rel_state", int'(state), 1);
      check("rel_y", int'(fish_y), 120);

      // Clamp at the left edge while caught.
      hook_en = 1'b1; hook_x = 10'd100; hook_y = 9'd125; tick();
      check("recap_state", int'(state), 2);
      hook_x = 10'd5; tick();
      check("clamp_lo_x", int'(fish_x), 0);

      // Asynchronous reset mid-capture.
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("arst_state", int'(state), 0);
      check("arst_x", int'(fish_x), 0);
      check("arst_y", int'(fish_y), 0);
      check("arst_act", int'(active), 0);
      check("arst_caught", int'(caught), 0);
      check("arst_esc", int'(escaped), 0);
      hook_en = 1'b0;
      tick();
      rst = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 5000; i++) begin
         spawn   = ($urandom_range(0, 3) == 0);
         spawn_x = 10'($urandom_range(0, 608));
         spawn_y = 9'($urandom_range(0, 464));
         way     = 2'($urandom_range(0, 3));
         hm      = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         vm      = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         if ($urandom_range(0, 9) == 0) hook_en = ~hook_en;
         if ($urandom_range(0, 1) == 0) begin
            int hx, hy;
            hx = m_x + int'($urandom_range(0, 44)) - 6;
            hy = m_y + int'($urandom_range(0, 30)) - 12;
            if (hx < 0) hx = 0;
            if (hx > 639) hx = 639;
            if (hy < 0) hy = 0;
            if (hy > 479) hy = 479;
            hook_x = 10'(hx); hook_y = 9'(hy);
         end else begin
            hook_x = 10'($urandom_range(0, 639));
            hook_y = 9'($urandom_range(0, 479));
         end
         if ($urandom_range(0, 499) == 0) do_reset();
         else tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
